// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the datapath and the multiply/divide unit.
// The master launches operations; the slave returns {hi, lo} and the HI/LO write strobe.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic        write_hilo;
  logic [63:0] result_64;
  logic        div_by_zero;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, write_hilo, result_64, div_by_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, write_hilo, result_64, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing {hi, lo}; 34-cycle latency.
// Define MDU_FAST_MUL_EN to route multiplies through a single-cycle array (2-cycle latency).
module mult_div_unit (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic [31:0] m_q, m_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        dbz_q, dbz_d;

  logic        accept;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum33, trial;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      m_q       <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    m_d       = m_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    dbz_d     = dbz_q;

    // DONE also accepts, so back-to-back ops issue every 34 cycles
    accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
    a_mag  = (!bus.op[0] && bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
    b_mag  = (!bus.op[0] && bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;

    sum33    = {1'b0, acc_q[63:32]} + {1'b0, m_q};
    trial    = acc_q[63:31] - {1'b0, m_q};
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
    rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          is_div_d  = bus.op[1];
          cnt_d     = '0;
          dbz_d     = 1'b0;
          neg_res_d = !bus.op[0] && (bus.rs_val[31] ^ bus.rt_val[31]);
          neg_rem_d = !bus.op[0] && bus.op[1] && bus.rs_val[31];
          state_d   = CALC;
          // Divide shifts the dividend through acc; multiply shifts the multiplier
          if (bus.op[1]) begin
            acc_d = {32'h0, a_mag};
            m_d   = b_mag;
          end else begin
            acc_d = {32'h0, b_mag};
            m_d   = a_mag;
          end
`ifdef MDU_FAST_MUL_EN
          if (!bus.op[1]) begin
            acc_d   = {32'h0, a_mag} * {32'h0, b_mag};
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        if (is_div_q) begin
          if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
          else            acc_d = {acc_q[62:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {sum33, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        // A zero divisor yields an all-ones quotient and the magnitude of A as remainder,
        // so the normal remainder sign fix already restores rs_val into hi.
        if (is_div_q) begin
          result_d = {rem_fix, (m_q == 32'h0) ? 32'hFFFF_FFFF : quo_fix};
          dbz_d    = (m_q == 32'h0);
        end else begin
          result_d = prod_fix;
        end
        state_d = DONE;
      end
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.write_hilo  = (state_q == DONE);
  assign bus.result_64   = result_q;
  assign bus.div_by_zero = dbz_q;
endmodule
